sc_pass_sequencer: RTL and testbench
====================================

# sc_pass_sequencer

Sequences multi-pass stochastic-computing (SC) operations on the bitstream datapath. Accepts a job over a valid/ready handshake and, for each pass:
- loads the stochastic number generators (SNGs);
- enables streaming for exactly `SC_LEN` cycles;
- waits out datapath drain latency;
- captures the accumulators.

After the final pass it reports completion over a second valid/ready handshake. It sits between the host/job controller and the SC array, and is the only driver of the array's load/enable/capture strobes.

## Interface
Parameters:
- `SC_LEN`, default `` `SC_LEN `` (256): bitstream length in cycles. Power of two, ≥2.
- `SC_LEN_LOG`, default `` `SC_LEN_LOG `` (8): log2(`SC_LEN`).
- `PASS_W`, default 8: width of the pass count.
- `DRAIN_CYC`, default 2: pipeline drain cycles between end of streaming and capture. Range 0..15.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start_valid` in 1: job request.
- `start_ready` out 1: sequencer idle, can accept a job.
- `num_passes` in `PASS_W`: passes for the job. Sampled on accept.
- `abort` in 1: cancel the current job.
- `sng_load` out 1: load SNG seeds/operands for the current pass.
- `acc_clear` out 1: clear accumulators. First pass only.
- `sc_enable` out 1: advance the bitstream datapath.
- `acc_capture` out 1: latch pass result.
- `pass_idx` out `PASS_W`: index of the current pass.
- `busy` out 1: job in progress.
- `done_valid` out 1: job complete.
- `done_ready` in 1: completion consumed.

## Operation
- All outputs are registered, decoded from state (Moore).
- States and behaviour:
  - **IDLE**:
    - `start_ready`=1.
    - On `start_valid` & `start_ready`: latch `num_passes`, set `pass_idx`=0.
    - If `num_passes`==0, go to DONE. Otherwise go to LOAD.
  - **LOAD** (1 cycle):
    - `sng_load`=1.
    - `acc_clear`=1 iff `pass_idx`==0.
    - Next state: RUN; cycle counter cleared.
  - **RUN**:
    - `sc_enable`=1.
    - Cycle counter (`SC_LEN_LOG` bits) increments each cycle.
    - When count == `SC_LEN`-1, go to DRAIN, or to CAPTURE if `DRAIN_CYC`==0.
  - **DRAIN**:
    - `sc_enable`=0.
    - Drain counter runs `DRAIN_CYC` cycles, then goes to CAPTURE.
  - **CAPTURE** (1 cycle):
    - `acc_capture`=1.
    - If `pass_idx`==latched passes−1, go to DONE. Otherwise `pass_idx`+1, go to LOAD.
  - **DONE**:
    - `done_valid`=1; held until `done_ready`.
    - On `done_ready`, go to IDLE.
- `busy`=1 in every state except IDLE.
- `abort`:
  - In LOAD, RUN, DRAIN or CAPTURE: go to IDLE next cycle. No `acc_capture`, no `done_valid`.
  - Ignored in IDLE and DONE.
  - Takes priority over every other transition in the same cycle.
- `num_passes`=2^`PASS_W`−1 must work. The pass compare uses the latched value and no overflow is possible.
- The cycle counter wraps naturally at `SC_LEN`. Its wrap coincides with leaving RUN.

## Timing
- Reset values:
  - State = IDLE.
  - `start_ready`=1.
  - `pass_idx`=0.
  - All other outputs = 0.
- Job accepted in cycle T (first pass):
  - LOAD in T+1.
  - RUN in T+2..T+1+`SC_LEN`.
  - DRAIN in the next `DRAIN_CYC` cycles.
  - CAPTURE in T+2+`SC_LEN`+`DRAIN_CYC`.
- Each pass takes `SC_LEN`+`DRAIN_CYC`+2 cycles.
- `sc_enable` is high for exactly `SC_LEN` consecutive cycles per pass.
- A `done_valid` & `done_ready` handshake in cycle D puts the block in IDLE at D+1. A new job can be accepted at D+1 at the earliest; `start_ready` is low during D.
- `num_passes`==0: accept at T gives `done_valid` at T+1, with no strobes.
- Reset mid-job takes effect next edge and overrides `abort` and the handshakes. All strobes are low the following cycle.

## Structure
- Shared package / `sys_defs.svh`:
  - `SC_LEN` and `SC_LEN_LOG`.
  - State enum `sc_seq_state_t` (IDLE, LOAD, RUN, DRAIN, CAPTURE, DONE).
- One sub-module, `sc_len_timer`:
  - Inputs: `clear`, `enable`.
  - Output: `terminal` (count == `SC_LEN`-1).
  - Used for the RUN count.
- The drain counter stays inline in the sequencer.

## Test plan
All scenarios use `SC_LEN`=16, `DRAIN_CYC`=2.
- **Single pass:** `num_passes`=1, accept at cycle 0 → `sng_load`+`acc_clear` at 1; `sc_enable` at 2..17; `acc_capture` at 20; `done_valid` at 21.
- **Three passes:** `num_passes`=3 → `acc_clear` only on the first `sng_load`; `pass_idx` 0,1,2; three `acc_capture` pulses spaced 20 cycles apart; then `done_valid`.
- **Zero passes:** `num_passes`=0 → `done_valid` at cycle 1; no `sng_load`, `sc_enable` or `acc_capture` ever.
- **Done backpressure:** hold `done_ready`=0 for 5 cycles → `done_valid` stable, `busy`=1, `start_ready`=0; IDLE one cycle after `done_ready`.
- **Abort mid-RUN:** `abort` at cycle 8 → IDLE at 9, `sc_enable`=0, no `acc_capture`/`done_valid`; a new job is accepted at 9.
- **Reset mid-job:** `reset` during DRAIN → all outputs at reset values next cycle; a subsequent job has nominal timing.

Source files
------------

// File: rtl/sc_pass_sequencer_pkg.sv
// Shared definitions for the stochastic-computing pass sequencer:
// default bitstream length and the sequencer state encoding.
package sc_pass_sequencer_pkg;

    localparam int unsigned SC_LEN     = 256;
    localparam int unsigned SC_LEN_LOG = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } sc_seq_state_t;

endpackage

// File: rtl/sc_pass_sequencer_len_timer.sv
// Bitstream-length timer: counts streaming cycles and flags the last one.
// terminal is registered and equals (count == SC_LEN-1).
module sc_len_timer #(
    parameter int unsigned SC_LEN     = sc_pass_sequencer_pkg::SC_LEN,
    parameter int unsigned SC_LEN_LOG = sc_pass_sequencer_pkg::SC_LEN_LOG
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [SC_LEN_LOG-1:0] CNT_PRE = SC_LEN_LOG'(SC_LEN - 2);

    logic [SC_LEN_LOG-1:0] cnt_q;

    // Count wraps naturally at SC_LEN; terminal is precomputed one step ahead.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q    <= '0;
            terminal <= 1'b0;
        end else if (enable) begin
            cnt_q    <= cnt_q + SC_LEN_LOG'(1);
            terminal <= (cnt_q == CNT_PRE);
        end
    end

endmodule

// File: rtl/sc_pass_sequencer.sv
// Multi-pass SC job sequencer: load, stream SC_LEN cycles, drain, capture,
// repeated per pass; reports completion over a valid/ready handshake.
module sc_pass_sequencer #(
    parameter int unsigned SC_LEN     = sc_pass_sequencer_pkg::SC_LEN,
    parameter int unsigned SC_LEN_LOG = sc_pass_sequencer_pkg::SC_LEN_LOG,
    parameter int unsigned PASS_W     = 8,
    parameter int unsigned DRAIN_CYC  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [PASS_W-1:0] num_passes,
    input  logic              abort,
    output logic              sng_load,
    output logic              acc_clear,
    output logic              sc_enable,
    output logic              acc_capture,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done_valid,
    input  logic              done_ready
);

    import sc_pass_sequencer_pkg::*;

    localparam int unsigned          DRAIN_W    = 4;
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = (DRAIN_CYC == 0) ? '0 : DRAIN_W'(DRAIN_CYC - 1);

    sc_seq_state_t       state_q, state_d;
    logic [PASS_W-1:0]   passes_q, passes_d;
    logic [PASS_W-1:0]   pass_idx_q, pass_idx_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                run_terminal;

    sc_len_timer #(
        .SC_LEN     (SC_LEN),
        .SC_LEN_LOG (SC_LEN_LOG)
    ) u_len_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_q == ST_LOAD),
        .enable   (state_q == ST_RUN),
        .terminal (run_terminal)
    );

    // Next-state logic; abort overrides every other transition while a pass is active.
    always_comb begin
        state_d    = state_q;
        passes_d   = passes_q;
        pass_idx_d = pass_idx_q;
        drain_d    = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    passes_d   = num_passes;
                    pass_idx_d = '0;
                    state_d    = (num_passes == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                drain_d = '0;
                if (run_terminal) begin
                    state_d = (DRAIN_CYC == 0) ? ST_CAPTURE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (pass_idx_q == passes_q - PASS_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    pass_idx_d = pass_idx_q + PASS_W'(1);
                    state_d    = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort && (state_q inside {ST_LOAD, ST_RUN, ST_DRAIN, ST_CAPTURE})) begin
            state_d    = ST_IDLE;
            pass_idx_d = pass_idx_q;
        end
    end

    // State and Moore outputs registered together from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            passes_q    <= '0;
            pass_idx_q  <= '0;
            drain_q     <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            sng_load    <= 1'b0;
            acc_clear   <= 1'b0;
            sc_enable   <= 1'b0;
            acc_capture <= 1'b0;
            done_valid  <= 1'b0;
        end else begin
            state_q     <= state_d;
            passes_q    <= passes_d;
            pass_idx_q  <= pass_idx_d;
            drain_q     <= drain_d;
            start_ready <= (state_d == ST_IDLE);
            busy        <= (state_d != ST_IDLE);
            sng_load    <= (state_d == ST_LOAD);
            acc_clear   <= (state_d == ST_LOAD) && (pass_idx_d == '0);
            sc_enable   <= (state_d == ST_RUN);
            acc_capture <= (state_d == ST_CAPTURE);
            done_valid  <= (state_d == ST_DONE);
        end
    end

    assign pass_idx = pass_idx_q;

endmodule

// File: tb/tb_sc_pass_sequencer.sv
// Randomized + directed bench for sc_pass_sequencer against a cycle-offset
// job-timeline model (SC_LEN=16, DRAIN_CYC=2).
module tb_sc_pass_sequencer;

    localparam int unsigned LEN = 16;
    localparam int unsigned LEN_LOG = 4;
    localparam int unsigned DRN = 2;
    localparam int unsigned PW  = 8;
    localparam int          P   = LEN + DRN + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [PW-1:0] num_passes = '0;
    logic          abort = 1'b0;
    logic          sng_load, acc_clear, sc_enable, acc_capture, busy, done_valid;
    logic [PW-1:0] pass_idx;
    logic          done_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0=idle 1=job active 2=done pending; k = cycles since accept.
    int m_mode = 0;
    int m_k    = 0;
    int m_np   = 0;
    int m_pidx = 0;
    bit m_ok   = 1'b0;

    always #5 clock = ~clock;

    sc_pass_sequencer #(
        .SC_LEN     (LEN),
        .SC_LEN_LOG (LEN_LOG),
        .PASS_W     (PW),
        .DRAIN_CYC  (DRN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .num_passes  (num_passes),
        .abort       (abort),
        .sng_load    (sng_load),
        .acc_clear   (acc_clear),
        .sc_enable   (sc_enable),
        .acc_capture (acc_capture),
        .pass_idx    (pass_idx),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit act;
        int j, pass, off;
        act  = (m_mode == 1);
        j    = m_k - 1;
        pass = act ? j / P : 0;
        off  = act ? j % P : 0;
        check("start_ready", 32'(start_ready), 32'(m_mode == 0));
        check("busy",        32'(busy),        32'(m_mode != 0));
        check("done_valid",  32'(done_valid),  32'(m_mode == 2));
        check("sng_load",    32'(sng_load),    32'(act && off == 0));
        check("acc_clear",   32'(acc_clear),   32'(act && off == 0 && pass == 0));
        check("sc_enable",   32'(sc_enable),   32'(act && off >= 1 && off <= LEN));
        check("acc_capture", 32'(acc_capture), 32'(act && off == P - 1));
        check("pass_idx",    32'(pass_idx),    32'(m_pidx));
    endtask

    task automatic model_step(input bit sv, input int np, input bit ab, input bit dr, input bit rst);
        int j;
        if (rst) begin
            m_mode = 0;
            m_pidx = 0;
            m_ok   = 1'b1;
        end else if (m_ok) begin
            case (m_mode)
                0: if (sv) begin
                    m_np   = np;
                    m_pidx = 0;
                    if (np == 0) m_mode = 2;
                    else begin
                        m_mode = 1;
                        m_k    = 1;
                    end
                end
                1: if (ab) m_mode = 0;
                   else begin
                       j = m_k - 1;
                       if (j % P == P - 1 && j / P == m_np - 1) m_mode = 2;
                       else begin
                           m_k++;
                           m_pidx = (m_k - 1) / P;
                       end
                   end
                default: if (dr) m_mode = 0;
            endcase
        end
    endtask

    // One clock: check at the falling edge, then drive inputs for the next rising edge.
    task automatic cyc(input bit sv, input int np, input bit ab, input bit dr, input bit rst);
        @(negedge clock);
        if (m_ok) check_outputs();
        start_valid = sv;
        num_passes  = PW'(np);
        abort       = ab;
        done_ready  = dr;
        reset       = rst;
        model_step(sv, np, ab, dr, rst);
    endtask

    task automatic idle_cycles(input int n, input bit dr);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, dr, 1'b0);
    endtask

    initial begin
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Single pass, three passes, zero passes with immediate completion consume.
        cyc(1'b1, 1, 1'b0, 1'b1, 1'b0);
        idle_cycles(P + 3, 1'b1);
        cyc(1'b1, 3, 1'b0, 1'b1, 1'b0);
        idle_cycles(3 * P + 3, 1'b1);
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle_cycles(6, 1'b0);              // done backpressure
        idle_cycles(2, 1'b1);

        // Abort mid-RUN, then immediate new job.
        cyc(1'b1, 2, 1'b0, 1'b1, 1'b0);
        idle_cycles(7, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1, 1'b0, 1'b1, 1'b0);
        idle_cycles(P + 3, 1'b1);

        // Reset during DRAIN, then nominal job.
        cyc(1'b1, 2, 1'b0, 1'b1, 1'b0);
        idle_cycles(LEN + 1, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1, 1'b0, 1'b1, 1'b0);
        idle_cycles(P + 3, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 4) == 0, int'($urandom % 5), ($urandom % 60) == 0,
                ($urandom % 3) == 0, ($urandom % 900) == 0);
        end
        idle_cycles(3, 1'b1);

        // Maximum pass count.
        cyc(1'b1, (1 << PW) - 1, 1'b0, 1'b0, 1'b0);
        idle_cycles(((1 << PW) - 1) * P + 4, 1'b0);
        idle_cycles(3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
